// File: rtl/axi4_lite_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_rom_arbiter_if
// Read-only AXI4-Lite bundle (AR + R channels) shared by the core masters,
// the ROM arbiter and the ROM wrapper. Write channels are absent because the
// ROM never accepts writes.
//
// Parameters : ADDR_WIDTH - AR address width, DATA_WIDTH - R data width
// Modports   : master - drives ARVALID/ARPROT/ARADDR/RREADY
//              slave  - drives ARREADY/RVALID/RRESP/RDATA
// ---------------------------------------------------------------------------
interface axi4_lite_rom_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ARVALID;
    logic [2:0]            ARPROT;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARREADY;
    logic                  RREADY;
    logic                  RVALID;
    logic [1:0]            RRESP;
    logic [DATA_WIDTH-1:0] RDATA;

    modport master (
        output ARVALID, ARPROT, ARADDR, RREADY,
        input  ARREADY, RVALID, RRESP, RDATA
    );

    modport slave (
        input  ARVALID, ARPROT, ARADDR, RREADY,
        output ARREADY, RVALID, RRESP, RDATA
    );
endinterface

// File: rtl/axi4_lite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_rom_arbiter
// Shares the boot/instruction ROM read port between the instruction-fetch
// master (s0) and the data/load master (s1). A single transaction is in
// flight at a time; the AR channel of the granted master is muxed onto m one
// cycle after arbitration and the R channel is passed straight back.
//
// Ports:
//   iCLK - clock
//   iRST - asynchronous active-low reset
//   s0   - slave modport facing the instruction-fetch master
//   s1   - slave modport facing the data/load master
//   m    - master modport facing the ROM wrapper
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN - when defined, s1 always wins a simultaneous request
//                       (s0 may starve); otherwise grant is round-robin.
// ---------------------------------------------------------------------------
module axi4_lite_rom_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    axi4_lite_rom_arbiter_if.slave        s0,
    axi4_lite_rom_arbiter_if.slave        s1,
    axi4_lite_rom_arbiter_if.master       m
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] RDATA_ZERO = '0;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   rr_last_q, rr_last_d;

    logic                  sel_arvalid;
    logic [2:0]            sel_arprot;
    logic [ADDR_WIDTH-1:0] sel_araddr;
    logic                  sel_rready;

    // rr_last resets to 1 so that s0 wins the very first tie.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Signals of the currently granted master, selected by the registered grant.
    always_comb begin
        sel_arvalid = grant_q ? s1.ARVALID : s0.ARVALID;
        sel_arprot  = grant_q ? s1.ARPROT  : s0.ARPROT;
        sel_araddr  = grant_q ? s1.ARADDR  : s0.ARADDR;
        sel_rready  = grant_q ? s1.RREADY  : s0.RREADY;
    end

    // Next-state and grant selection.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (s0.ARVALID || s1.ARVALID) begin
                    state_d = ADDR;
                    if (s0.ARVALID && s1.ARVALID) begin
`ifdef ARB_FIXED_PRIO_EN
                        grant_d = 1'b1;
`else
                        grant_d = ~rr_last_q;
`endif
                    end else begin
                        grant_d = s1.ARVALID;
                    end
                end
            end
            ADDR: begin
                // A master that drops ARVALID early simply stalls us here.
                if (sel_arvalid && m.ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m.RVALID && sel_rready) begin
                    rr_last_d = grant_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel routing; everything is zero outside the phase that owns it,
    // so a slave RVALID seen in IDLE/ADDR is never accepted.
    always_comb begin
        m.ARVALID  = 1'b0;
        m.ARPROT   = 3'b000;
        m.ARADDR   = '0;
        m.RREADY   = 1'b0;
        s0.ARREADY = 1'b0;
        s0.RVALID  = 1'b0;
        s0.RRESP   = 2'b00;
        s0.RDATA   = RDATA_ZERO;
        s1.ARREADY = 1'b0;
        s1.RVALID  = 1'b0;
        s1.RRESP   = 2'b00;
        s1.RDATA   = RDATA_ZERO;
        case (state_q)
            ADDR: begin
                m.ARVALID = sel_arvalid;
                m.ARPROT  = sel_arprot;
                m.ARADDR  = sel_araddr;
                if (grant_q) begin
                    s1.ARREADY = m.ARREADY;
                end else begin
                    s0.ARREADY = m.ARREADY;
                end
            end
            DATA: begin
                m.RREADY = sel_rready;
                if (grant_q) begin
                    s1.RVALID = m.RVALID;
                    s1.RRESP  = m.RRESP;
                    s1.RDATA  = m.RDATA;
                end else begin
                    s0.RVALID = m.RVALID;
                    s0.RRESP  = m.RRESP;
                    s0.RDATA  = m.RDATA;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
